lsu_wb: RTL and testbench

LSU_WB -- requirements
Module: lsu_wb

---
 rtl/lsu_wb_pkg.sv | 26 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_wb.sv | 144 ++++++++++++++
 tb/tb_lsu_wb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_wb_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I width codes,
// the zero word and the misalignment predicate used when trapping is compiled in.
// No logic of its own; imported by lsu_align and lsu_wb.
package lsu_wb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2,
      S_WB     = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replicated write data, load lane extract and extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_align
   import lsu_wb_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] st_data,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (lane)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

      // Byte/halfword data is replicated so every strobed lane sees the right bits.
      case (funct3[1:0])
         2'b00: begin
            wstrb = 4'b0001 << lane;
            wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            wstrb = 4'b0011 << {lane[1], 1'b0};
            wdata = {2{st_data[15:0]}};
         end
         default: begin
            wstrb = 4'b1111;
            wdata = st_data;
         end
      endcase

      case (funct3)
         F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
         F3_W:    ld_data = rdata;
         F3_BU:   ld_data = {24'd0, byte_sel};
         F3_HU:   ld_data = {16'd0, half_sel};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_wb.sv
// Single-outstanding load/store unit with register-file writeback; LSU_MISALIGN_TRAP_EN adds misalignment traps.
// Latency: load accept to reg_write >= 3 cycles; store retires the cycle after mem_gnt.
// Backpressure: ex_ready only in IDLE; request held stable until mem_gnt, aborted after TIMEOUT_CYCLES.
module lsu_wb
   import lsu_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_load,
   input  logic        ex_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic [31:0] data_write,
   output logic        bus_err
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   lsu_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q;
   logic [31:0]   dat_q;
   logic [4:0]    rd_q;
   logic          is_load_q;
   logic          bus_err_q;

   logic          accept_op, ld_capture, timeout, trap, timeout_hit;
   logic [3:0]    al_wstrb;
   logic [31:0]   al_wdata, al_ld_data;

   lsu_align u_align (
      .funct3  (f3_q),
      .lane    (addr_q[1:0]),
      .st_data (dat_q),
      .rdata   (mem_rdata),
      .wstrb   (al_wstrb),
      .wdata   (al_wdata),
      .ld_data (al_ld_data)
   );

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      ex_ready   = 1'b0;
      mem_req    = 1'b0;
      reg_write  = 1'b0;
      accept_op  = 1'b0;
      ld_capture = 1'b0;
      timeout    = 1'b0;
      trap       = 1'b0;
      case (state_q)
         S_IDLE: begin
            ex_ready = 1'b1;
            if (ex_valid && (ex_load ^ ex_store)) begin
               accept_op = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
               if (misaligned(ex_funct3, ex_addr[1:0])) trap = 1'b1;
               else                                     state_d = S_REQ;
`else
               state_d = S_REQ;
`endif
            end
         end
         S_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt)          state_d = is_load_q ? S_WAIT_R : S_IDLE;
            else if (timeout_hit) begin
               timeout = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WAIT_R: begin
            // Read data arriving alongside the grant was seen in S_REQ and is dropped.
            if (mem_rvalid) begin
               ld_capture = 1'b1;
               state_d    = S_WB;
            end else if (timeout_hit) begin
               timeout = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WB: begin
            reg_write = (rd_q != 5'd0);
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         f3_q      <= 3'd0;
         addr_q    <= ZERO_WORD;
         dat_q     <= ZERO_WORD;
         rd_q      <= 5'd0;
         is_load_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bus_err_q <= timeout | trap;
         // Counter restarts on every state change, so each REQ/WAIT_R dwell is timed separately.
         if (state_d != state_q)                          cnt_q <= '0;
         else if (state_q == S_REQ || state_q == S_WAIT_R) cnt_q <= cnt_q + CW'(1);
         if (accept_op) begin
            f3_q      <= ex_funct3;
            addr_q    <= ex_addr;
            dat_q     <= ex_store_data;
            rd_q      <= ex_rd;
            is_load_q <= ex_load;
         end else if (ld_capture) begin
            dat_q <= al_ld_data;
         end
      end
   end

   assign mem_we     = mem_req && !is_load_q;
   assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : ZERO_WORD;
   assign mem_wstrb  = mem_we ? al_wstrb : 4'b0000;
   assign mem_wdata  = mem_we ? al_wdata : ZERO_WORD;
   assign rd         = (state_q == S_WB) ? rd_q : 5'd0;
   assign data_write = (state_q == S_WB) ? dat_q : ZERO_WORD;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb built with TIMEOUT_CYCLES=4; misalignment expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_wb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ex_valid, ex_ready, ex_load, ex_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_store_data;
   logic [4:0]  ex_rd;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt, mem_rvalid;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] data_write;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_wb #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .reg_write(reg_write), .rd(rd), .data_write(data_write), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=hang expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
      ex_valid = 1'b1; ex_load = ld; ex_store = st;
      ex_funct3 = f3; ex_addr = a; ex_store_data = d; ex_rd = r;
      step();
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
   endtask

   // Issue a load, grant immediately, return data next cycle; leaves the bench in the WB cycle.
   task automatic load_to_wb(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rdat, input logic [4:0] r);
      issue(1'b1, 1'b0, f3, a, 32'h0, r);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdat;
      step();
      mem_rvalid = 1'b0;
   endtask

   task automatic store_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] strb, input logic [31:0] wd);
      issue(1'b0, 1'b1, f3, a, d, 5'd0);
      chk({tag, "_we"},    {31'd0, mem_we}, 32'd1);
      chk({tag, "_strb"},  {28'd0, mem_wstrb}, {28'd0, strb});
      chk({tag, "_wdata"}, mem_wdata, wd);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk({tag, "_idle"},  {31'd0, ex_ready}, 32'd1);
   endtask

   initial begin
      reset_n = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      ex_funct3 = 3'd0; ex_addr = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #3;
      chk("rst_ready",  {31'd0, ex_ready}, 32'd1);
      chk("rst_req",    {31'd0, mem_req}, 32'd0);
      chk("rst_regwr",  {31'd0, reg_write}, 32'd0);
      chk("rst_buserr", {31'd0, bus_err}, 32'd0);
      chk("rst_addr",   mem_addr, 32'h0);
      step(); step();
      reset_n = 1'b1;
      step();

      // SW with grant delayed two cycles: request held stable throughout.
      issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
      chk("sw_req",   {31'd0, mem_req}, 32'd1);
      chk("sw_ready", {31'd0, ex_ready}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         chk("sw_strb",  {28'd0, mem_wstrb}, 32'hF);
         chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
         chk("sw_addr",  mem_addr, 32'h100);
         step();
      end
      mem_gnt = 1'b1;
      chk("sw_hold", mem_wdata, 32'hDEADBEEF);
      step();
      mem_gnt = 1'b0;
      chk("sw_idle_rdy", {31'd0, ex_ready}, 32'd1);
      chk("sw_idle_req", {31'd0, mem_req}, 32'd0);

      store_check("sb", 3'b000, 32'h102, 32'h0000_00AB, 4'b0100, 32'hABAB_ABAB);
      store_check("sh", 3'b001, 32'h102, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);

      load_to_wb(3'b000, 32'h103, 32'h80FF_FF7F, 5'd1);
      chk("lb_regwr", {31'd0, reg_write}, 32'd1);
      chk("lb_rd",    {27'd0, rd}, 32'd1);
      chk("lb_data",  data_write, 32'hFFFF_FF80);
      step();
      chk("lb_pulse", {31'd0, reg_write}, 32'd0);
      chk("lb_ready", {31'd0, ex_ready}, 32'd1);

      load_to_wb(3'b100, 32'h103, 32'h80FF_FF7F, 5'd2);
      chk("lbu_data", data_write, 32'h0000_0080);
      step();

      load_to_wb(3'b001, 32'h002, 32'h8001_0000, 5'd0);
      chk("lh_rd0_regwr", {31'd0, reg_write}, 32'd0);
      chk("lh_rd0_in_wb", {31'd0, ex_ready}, 32'd0);
      step();
      chk("lh_rd0_idle",  {31'd0, ex_ready}, 32'd1);

      load_to_wb(3'b101, 32'h002, 32'h8001_0000, 5'd5);
      chk("lhu_regwr", {31'd0, reg_write}, 32'd1);
      chk("lhu_rd",    {27'd0, rd}, 32'd5);
      chk("lhu_data",  data_write, 32'h0000_8001);
      step();

      // Read data coincident with grant must be ignored.
      issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd3);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      step();
      chk("gnt_rv_regwr", {31'd0, reg_write}, 32'd0);
      chk("gnt_rv_wait",  {31'd0, ex_ready}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      mem_rvalid = 1'b0;
      chk("lw_regwr", {31'd0, reg_write}, 32'd1);
      chk("lw_data",  data_write, 32'h1234_5678);
      step();

      // Neither/both op flags: consumed without bus traffic.
      issue(1'b1, 1'b1, 3'b010, 32'h400, 32'h0, 5'd4);
      chk("bad_op_req",   {31'd0, mem_req}, 32'd0);
      chk("bad_op_ready", {31'd0, ex_ready}, 32'd1);

      // Timeout in WAIT_R: four cycles without rvalid.
      issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd6);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("to_wait_err", {31'd0, bus_err}, 32'd0);
         step();
      end
      chk("to_wait_err4", {31'd0, bus_err}, 32'd0);
      step();
      chk("to_err",   {31'd0, bus_err}, 32'd1);
      chk("to_ready", {31'd0, ex_ready}, 32'd1);
      chk("to_regwr", {31'd0, reg_write}, 32'd0);
      step();
      chk("to_pulse", {31'd0, bus_err}, 32'd0);

      // Timeout in REQ: grant never comes.
      issue(1'b0, 1'b1, 3'b010, 32'h500, 32'h1, 5'd0);
      step(); step(); step();
      chk("to_req_still", {31'd0, mem_req}, 32'd1);
      step();
      chk("to_req_err",  {31'd0, bus_err}, 32'd1);
      chk("to_req_drop", {31'd0, mem_req}, 32'd0);
      step();

      // Asynchronous reset while waiting for read data.
      issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd7);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_ready", {31'd0, ex_ready}, 32'd1);
      chk("arst_req",   {31'd0, mem_req}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      step();
      reset_n = 1'b1;
      step();
      mem_rvalid = 1'b0;
      chk("arst_regwr", {31'd0, reg_write}, 32'd0);
      chk("arst_err",   {31'd0, bus_err}, 32'd0);
      chk("arst_data",  data_write, 32'h0);
      step();
      chk("arst_idle",  {31'd0, ex_ready}, 32'd1);

      // Misaligned word load.
      issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd7);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_req",   {31'd0, mem_req}, 32'd0);
      chk("mis_err",   {31'd0, bus_err}, 32'd1);
      chk("mis_ready", {31'd0, ex_ready}, 32'd1);
      step();
      chk("mis_req2",  {31'd0, mem_req}, 32'd0);
      chk("mis_pulse", {31'd0, bus_err}, 32'd0);
`else
      chk("mis_req",  {31'd0, mem_req}, 32'd1);
      chk("mis_addr", mem_addr, 32'h100);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_rvalid = 1'b0;
      chk("mis_data", data_write, 32'hCAFE_F00D);
      chk("mis_err",  {31'd0, bus_err}, 32'd0);
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
